// File: rtl/vote_ctrl_if.sv
// Ballot bus and session control/status signals of the weighted vote controller.
interface vote_ctrl_if;
   logic        start;
   logic        close;
   logic        b_valid;
   logic        b_ready;
   logic [1:0]  b_class;
   logic        b_yes;
   logic        busy;
   logic        done;
   logic        res;
   logic [11:0] yes_w;
   logic [11:0] no_w;
   logic        ovf;

   // Session controller / ballot source side
   modport master (
      output start, close, b_valid, b_class, b_yes,
      input  b_ready, busy, done, res, yes_w, no_w, ovf
   );

   // Vote controller side
   modport slave (
      input  start, close, b_valid, b_class, b_yes,
      output b_ready, busy, done, res, yes_w, no_w, ovf
   );
endinterface

// File: rtl/vote_ctrl.sv
// Weighted vote controller: collects capped normal/VIP/VVIP ballots, tallies
// yes/no weight and produces a decision with a VVIP tie-break.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; last decision and tallies held
// COLLECT | ballots accepted (b_ready=1) until close or all caps reached
// DECIDE  | one cycle: compare tallies, latch res
// DONE    | one cycle: done strobe, then back to IDLE
module vote_ctrl #(
   parameter int W_NP   = 1,
   parameter int W_VIP  = 4,
   parameter int W_VVIP = 16
) (
   input logic     clk,
   input logic     rst_n,
   vote_ctrl_if.slave bus
);

   localparam logic [11:0] L_W_NP   = 12'(W_NP);
   localparam logic [11:0] L_W_VIP  = 12'(W_VIP);
   localparam logic [11:0] L_W_VVIP = 12'(W_VVIP);
   localparam logic [5:0]  L_CAP_NP  = 6'd32;
   localparam logic [3:0]  L_CAP_VIP = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DECIDE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [11:0] r_yes_w;
   logic [11:0] r_no_w;
   logic [5:0]  r_cnt_np;
   logic [3:0]  r_cnt_vip;
   logic        r_vvip_cast;
   logic        r_vvip_vote;
   logic        r_ovf;
   logic        r_res;

   logic        w_take;
   logic        w_hit;
   logic        w_drop;
   logic [11:0] w_add;
   logic [5:0]  w_cnt_np_nxt;
   logic [3:0]  w_cnt_vip_nxt;
   logic        w_vvip_cast_nxt;
   logic        w_full;
   logic        w_res_dec;

   assign w_take = bus.b_valid && (r_state == S_COLLECT);

   // Classify the ballot on the bus: counted (w_hit) or discarded (w_drop)
   always_comb begin
      w_hit           = 1'b0;
      w_drop          = 1'b0;
      w_add           = '0;
      w_cnt_np_nxt    = r_cnt_np;
      w_cnt_vip_nxt   = r_cnt_vip;
      w_vvip_cast_nxt = r_vvip_cast;
      if (w_take) begin
         case (bus.b_class)
            2'd0: begin
               if (r_cnt_np != L_CAP_NP) begin
                  w_hit        = 1'b1;
                  w_add        = L_W_NP;
                  w_cnt_np_nxt = r_cnt_np + 6'd1;
               end else begin
                  w_drop = 1'b1;
               end
            end
            2'd1: begin
               if (r_cnt_vip != L_CAP_VIP) begin
                  w_hit         = 1'b1;
                  w_add         = L_W_VIP;
                  w_cnt_vip_nxt = r_cnt_vip + 4'd1;
               end else begin
                  w_drop = 1'b1;
               end
            end
            2'd2: begin
               if (!r_vvip_cast) begin
                  w_hit           = 1'b1;
                  w_add           = L_W_VVIP;
                  w_vvip_cast_nxt = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end
            default: w_drop = 1'b1;
         endcase
      end
   end

   // Caps are judged on the post-ballot counts so the last counted ballot
   // moves to DECIDE on the same edge, matching the close latency.
   assign w_full = (w_cnt_np_nxt == L_CAP_NP) && (w_cnt_vip_nxt == L_CAP_VIP)
                   && w_vvip_cast_nxt;

   // Tie goes to the VVIP ballot when one was counted, otherwise to "no"
   assign w_res_dec = (r_yes_w > r_no_w) ? 1'b1 :
                      (r_yes_w < r_no_w) ? 1'b0 :
                      (r_vvip_cast & r_vvip_vote);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.start) w_state_nxt = S_COLLECT;
         S_COLLECT: if (bus.close || w_full) w_state_nxt = S_DECIDE;
         S_DECIDE:  w_state_nxt = S_DONE;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Tallies, class counters, VVIP record, overflow flag and decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_yes_w     <= '0;
         r_no_w      <= '0;
         r_cnt_np    <= '0;
         r_cnt_vip   <= '0;
         r_vvip_cast <= 1'b0;
         r_vvip_vote <= 1'b0;
         r_ovf       <= 1'b0;
         r_res       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_yes_w     <= '0;
                  r_no_w      <= '0;
                  r_cnt_np    <= '0;
                  r_cnt_vip   <= '0;
                  r_vvip_cast <= 1'b0;
                  r_vvip_vote <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_res       <= 1'b0;
               end
            end
            S_COLLECT: begin
               r_cnt_np    <= w_cnt_np_nxt;
               r_cnt_vip   <= w_cnt_vip_nxt;
               r_vvip_cast <= w_vvip_cast_nxt;
               if (w_hit) begin
                  if (bus.b_yes) begin
                     r_yes_w <= r_yes_w + w_add;
                  end else begin
                     r_no_w <= r_no_w + w_add;
                  end
                  if (bus.b_class == 2'd2) begin
                     r_vvip_vote <= bus.b_yes;
                  end
               end
               if (w_drop) begin
                  r_ovf <= 1'b1;
               end
            end
            S_DECIDE: r_res <= w_res_dec;
            default: ;
         endcase
      end
   end

   // Outputs decoded from state and registers
   always_comb begin
      bus.b_ready = (r_state == S_COLLECT);
      bus.busy    = (r_state != S_IDLE);
      bus.done    = (r_state == S_DONE);
      bus.res     = r_res;
      bus.yes_w   = r_yes_w;
      bus.no_w    = r_no_w;
      bus.ovf     = r_ovf;
   end

endmodule

// File: tb/tb_vote_ctrl.sv
// Scoreboard bench for vote_ctrl: a behavioural tally model pushes the
// expected result when a session is closed; a monitor pops it on done.
module tb_vote_ctrl;

   localparam int P_W_NP   = 1;
   localparam int P_W_VIP  = 4;
   localparam int P_W_VVIP = 16;

   logic clk;
   logic rst_n;
   int unsigned cyc;
   int unsigned n_chk;
   int unsigned n_fail;

   vote_ctrl_if vif ();

   vote_ctrl #(
      .W_NP   (P_W_NP),
      .W_VIP  (P_W_VIP),
      .W_VVIP (P_W_VVIP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] y;
      logic [11:0] n;
      logic        r;
      logic        o;
      int unsigned dcyc;
   } exp_t;

   exp_t sbq[$];

   // model state
   int     m_yes, m_no, m_cn, m_cv, m_cvv;
   logic   m_vvote, m_ovf, m_collect, m_res;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_res();
      if (m_yes > m_no) return 1'b1;
      if (m_yes < m_no) return 1'b0;
      return (m_cvv != 0) ? m_vvote : 1'b0;
   endfunction

   // called right after the edge that closes collection
   task automatic push_exp();
      exp_t e;
      e.y    = 12'(m_yes);
      e.n    = 12'(m_no);
      e.r    = model_res();
      e.o    = m_ovf;
      e.dcyc = cyc + 1;
      m_res  = e.r;
      sbq.push_back(e);
      m_collect = 1'b0;
   endtask

   task automatic model_clear();
      m_yes = 0; m_no = 0; m_cn = 0; m_cv = 0; m_cvv = 0;
      m_vvote = 1'b0; m_ovf = 1'b0; m_res = 1'b0; m_collect = 1'b0;
   endtask

   task automatic do_start();
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      model_clear();
      m_collect = 1'b1;
      chk("start_busy", vif.busy, 1);
      chk("start_ready", vif.b_ready, 1);
      chk("start_yes_w", vif.yes_w, 0);
      chk("start_no_w", vif.no_w, 0);
      chk("start_ovf", vif.ovf, 0);
      chk("start_res", vif.res, 0);
   endtask

   task automatic send(input logic [1:0] cls, input logic yes, input logic cl);
      bit counted;
      int w;
      vif.b_valid = 1'b1;
      vif.b_class = cls;
      vif.b_yes   = yes;
      vif.close   = cl;
      @(posedge clk); #1;
      vif.b_valid = 1'b0;
      vif.close   = 1'b0;
      counted = 0;
      w = 0;
      case (cls)
         2'd0: if (m_cn < 32)  begin counted = 1; m_cn++;  w = P_W_NP;  end
         2'd1: if (m_cv < 8)   begin counted = 1; m_cv++;  w = P_W_VIP; end
         2'd2: if (m_cvv < 1)  begin counted = 1; m_cvv++; w = P_W_VVIP; m_vvote = yes; end
         default: counted = 0;
      endcase
      if (counted) begin
         if (yes) m_yes += w;
         else     m_no  += w;
      end else begin
         m_ovf = 1'b1;
      end
      chk("tally_yes_w", vif.yes_w, m_yes);
      chk("tally_no_w", vif.no_w, m_no);
      chk("tally_ovf", vif.ovf, m_ovf);
      if (cl || (m_cn == 32 && m_cv == 8 && m_cvv == 1)) push_exp();
   endtask

   task automatic do_close();
      vif.close = 1'b1;
      @(posedge clk); #1;
      vif.close = 1'b0;
      push_exp();
   endtask

   // wait (bounded) until the scoreboard drains, then check the held result
   task automatic wait_done();
      for (int i = 0; i < 8 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         chk("done_timeout", 0, 1);
         sbq.delete();
      end
      @(posedge clk); #1;
      chk("idle_busy", vif.busy, 0);
      chk("idle_ready", vif.b_ready, 0);
      chk("idle_res_held", vif.res, m_res);
   endtask

   // monitor: pop expected result on every done strobe
   always @(negedge clk) begin
      if (vif.done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_yes_w", vif.yes_w, e.y);
            chk("done_no_w", vif.no_w, e.n);
            chk("done_res", vif.res, e.r);
            chk("done_ovf", vif.ovf, e.o);
            chk("done_latency", cyc, e.dcyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] vip_pat;
      n_chk = 0; n_fail = 0; cyc = 0;
      rst_n = 1'b0;
      vif.start = 1'b0; vif.close = 1'b0; vif.b_valid = 1'b0;
      vif.b_class = 2'd0; vif.b_yes = 1'b0;
      model_clear();
      @(negedge clk); @(negedge clk);
      chk("rst_busy", vif.busy, 0);
      chk("rst_ready", vif.b_ready, 0);
      chk("rst_done", vif.done, 0);
      chk("rst_res", vif.res, 0);
      chk("rst_ovf", vif.ovf, 0);
      chk("rst_yes_w", vif.yes_w, 0);
      chk("rst_no_w", vif.no_w, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // close outside COLLECT is ignored
      vif.close = 1'b1;
      @(posedge clk); #1;
      vif.close = 1'b0;
      chk("close_in_idle", vif.busy, 0);

      // full session: 32 normal yes, VIP 1010_1001, VVIP yes -> auto decide
      do_start();
      for (int i = 0; i < 32; i++) send(2'd0, 1'b1, 1'b0);
      vip_pat = 8'b1010_1001;
      for (int i = 7; i >= 0; i--) send(2'd1, vip_pat[i], 1'b0);
      send(2'd2, 1'b1, 1'b0);
      chk("auto_yes_w", vif.yes_w, 64);
      chk("auto_no_w", vif.no_w, 16);
      chk("auto_ready", vif.b_ready, 0);
      wait_done();
      chk("auto_res", vif.res, 1);

      // mixed session, start pulsed mid-collect must be ignored
      do_start();
      send(2'd0, 1'b1, 1'b0);
      send(2'd0, 1'b1, 1'b0);
      send(2'd1, 1'b0, 1'b0);
      vif.start = 1'b1;
      @(posedge clk); #1;
      vif.start = 1'b0;
      chk("start_ignored_yes", vif.yes_w, 2);
      chk("start_ignored_no", vif.no_w, 4);
      send(2'd0, 1'b1, 1'b0);
      send(2'd0, 1'b1, 1'b0);
      send(2'd2, 1'b0, 1'b0);
      do_close();
      wait_done();
      chk("mixed_res", vif.res, 0);

      // tie with no VVIP -> 0
      do_start();
      for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 1'b0);
      send(2'd1, 1'b1, 1'b0);
      do_close();
      wait_done();

      // tie with VVIP yes -> 1 (20/20)
      do_start();
      for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 1'b0);
      send(2'd1, 1'b1, 1'b0);
      send(2'd2, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) send(2'd0, 1'b0, 1'b0);
      do_close();
      wait_done();
      chk("tie_vvip_yes", vif.res, 1);

      // tie with VVIP no -> 0 (20/20)
      do_start();
      for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 1'b0);
      send(2'd1, 1'b1, 1'b0);
      send(2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(2'd1, 1'b1, 1'b0);
      do_close();
      wait_done();

      // overflow: second VVIP and class 3 discarded, ovf sticky
      do_start();
      send(2'd2, 1'b1, 1'b0);
      send(2'd2, 1'b0, 1'b0);
      chk("ovf_vvip2", vif.ovf, 1);
      send(2'd3, 1'b1, 1'b0);
      send(2'd0, 1'b0, 1'b0);
      chk("ovf_sticky", vif.ovf, 1);
      do_close();
      wait_done();
      chk("ovf_held_idle", vif.ovf, 1);
      do_start();
      chk("ovf_cleared", vif.ovf, 0);

      // reset mid-session: 5 ballots then abort
      for (int i = 0; i < 5; i++) send(2'd1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_yes_w", vif.yes_w, 0);
      chk("abort_busy", vif.busy, 0);
      chk("abort_ready", vif.b_ready, 0);
      chk("abort_done", vif.done, 0);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", vif.busy, 0);
      do_start();
      send(2'd0, 1'b1, 1'b0);
      send(2'd0, 1'b1, 1'b0);
      send(2'd0, 1'b1, 1'b0);
      do_close();
      wait_done();
      chk("post_rst_yes_w", vif.yes_w, 3);

      // close together with a VIP yes ballot
      do_start();
      send(2'd0, 1'b0, 1'b0);
      send(2'd1, 1'b1, 1'b1);
      chk("close_vip_yes_w", vif.yes_w, 4);
      wait_done();
      chk("close_vip_res", vif.res, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
